alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 70 +++++++
 tb/tb_alu_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter that issues one op at a time to a shared ALU and returns a handshaked response
module alu_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [2:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        req1_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [7:0]  ovf_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, gnt, acc, hs;
  always_comb begin
    gnt = (req0_valid & req1_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_grant) : req1_valid;
    acc = (state == IDLE) & (req0_valid | req1_valid);
    hs = (state == RESP) & rsp_ready;
    state_nx = acc ? ISSUE : (state == ISSUE) ? RESP : hs ? IDLE : state;
  end
  assign req0_ready = acc & ~gnt;
  assign req1_ready = acc & gnt;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= 1'b1;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_overflow <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (acc) begin
        last_grant <= gnt;
        alu_a <= gnt ? req1_a : req0_a;
        alu_b <= gnt ? req1_b : req0_b;
        alu_ctrl <= gnt ? req1_op : req0_op;
        rsp_id <= gnt;
      end
      if (state == ISSUE) begin
        rsp_result <= (alu_ctrl == 3'b011) ? alu_result : {16'h0000, alu_result[15:0]};
        rsp_overflow <= (alu_ctrl[2:1] == 2'b00) & alu_overflow;
      end
      if (hs && rsp_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU stub
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1, force_ovf = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_overflow, busy, alu_overflow;
  logic [15:0] alu_a, alu_b;
  logic [2:0] alu_ctrl;
  logic [31:0] alu_result, rsp_result;
  logic [7:0] ovf_count;
  logic req0_ready_f, req1_ready_f, rsp_valid_f, rsp_id_f, rsp_overflow_f, busy_f, alu_overflow_f;
  logic [15:0] alu_a_f, alu_b_f;
  logic [2:0] alu_ctrl_f;
  logic [31:0] alu_result_f, rsp_result_f;
  logic [7:0] ovf_count_f;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_ready(rsp_ready), .busy(busy), .ovf_count(ovf_count)
  );
  alu_arbiter #(.FIXED_PRIO(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready_f),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready_f),
    .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_ctrl(alu_ctrl_f), .alu_result(alu_result_f), .alu_overflow(alu_overflow_f),
    .rsp_valid(rsp_valid_f), .rsp_id(rsp_id_f), .rsp_result(rsp_result_f), .rsp_overflow(rsp_overflow_f),
    .rsp_ready(rsp_ready), .busy(busy_f), .ovf_count(ovf_count_f)
  );
  function automatic logic [32:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic f);
    logic [15:0] s;
    logic v;
    s = (op == 3'd0) ? a + b : a - b;
    v = (op == 3'd0) ? (a[15] == b[15] && s[15] != a[15]) : (a[15] != b[15] && s[15] != a[15]);
    case (op)
      3'd0, 3'd1: return {v | f, 16'hFFFF, s};
      3'd2: return {f, 16'hFFFF, a};
      3'd3: return {f, a, b};
      3'd4: return {f, 16'hFFFF, a & b};
      default: return {f, 16'hFFFF, a | b};
    endcase
  endfunction
  always_comb {alu_overflow, alu_result} = alu_model(alu_a, alu_b, alu_ctrl, force_ovf);
  always_comb {alu_overflow_f, alu_result_f} = alu_model(alu_a_f, alu_b_f, alu_ctrl_f, force_ovf);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input logic who, input logic [15:0] a, input logic [15:0] b, input logic [2:0] code,
                    input logic [31:0] exp_res, input logic exp_ovf);
    @(negedge clk);
    req0_valid = !who; req1_valid = who;
    if (who) begin req1_a = a; req1_b = b; req1_op = code; end
    else begin req0_a = a; req0_b = b; req0_op = code; end
    #1;
    check("op_rdy0", req0_ready, !who);
    check("op_rdy1", req1_ready, who);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("issue_rsp_valid", rsp_valid, 1'b0);
    check("issue_busy", busy, 1'b1);
    @(negedge clk);
    #1;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_id", rsp_id, who);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_overflow", rsp_overflow, exp_ovf);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_ctrl", alu_ctrl, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_ovf_count", ovf_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("rr_grant", {req1_ready, req0_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
      check("fp_grant", {req1_ready_f, req0_ready_f}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("resp_no_ready", {req1_ready, req0_ready}, 32'd0);
      check("rr_rsp_id", rsp_id, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = 3'd0;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_alu_a", alu_a, 32'h0);
    check("midrst_alu_b", alu_b, 32'h0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rsp_id", rsp_id, 1'b0);
    check("midrst_rsp_ovf", rsp_overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_rsp", rsp_valid, 1'b0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'h0000; req0_b = 16'h0000; req0_op = 3'd0;
    #1;
    check("first_grant_0", {req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    op(1'b0, 16'h7FFF, 16'h0001, 3'd0, 32'h0000_8000, 1'b1);
    @(negedge clk);
    #1;
    check("ovf_count_add", ovf_count, 32'd1);
    check("idle_busy", busy, 1'b0);
    check("hold_alu_a", alu_a, 32'h7FFF);
    op(1'b1, 16'h1234, 16'hABCD, 3'd3, 32'h1234_ABCD, 1'b0);
    op(1'b0, 16'hF0F0, 16'h0FF0, 3'd4, 32'h0000_00F0, 1'b0);
    op(1'b1, 16'hF000, 16'h000F, 3'd5, 32'h0000_F00F, 1'b0);
    op(1'b0, 16'h1200, 16'h0034, 3'd7, 32'h0000_1234, 1'b0);
    op(1'b0, 16'h8000, 16'h0001, 3'd1, 32'h0000_7FFF, 1'b1);
    force_ovf = 1'b1;
    op(1'b1, 16'h5555, 16'h0000, 3'd2, 32'h0000_5555, 1'b0);
    force_ovf = 1'b0;
    @(negedge clk);
    #1;
    check("ovf_count_move", ovf_count, 32'd2);
    rsp_ready = 1'b0;
    op(1'b1, 16'h0005, 16'h0003, 3'd1, 32'h0000_0002, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_rsp_result", rsp_result, 32'h0000_0002);
      check("stall_rsp_id", rsp_id, 1'b1);
      check("stall_ready", {req1_ready, req0_ready}, 32'd0);
      check("stall_busy", busy, 1'b1);
      check("stall_alu_a", alu_a, 32'h0005);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_cycle_ready", {req1_ready, req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("after_hs_busy", busy, 1'b0);
    check("after_hs_grant", {req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 255; i++) op(1'b0, 16'h8000, 16'h0001, 3'd1, 32'h0000_7FFF, 1'b1);
    @(negedge clk);
    #1;
    check("ovf_count_ff", ovf_count, 32'hFF);
    op(1'b1, 16'h8000, 16'h0001, 3'd1, 32'h0000_7FFF, 1'b1);
    op(1'b0, 16'h8000, 16'h0001, 3'd1, 32'h0000_7FFF, 1'b1);
    @(negedge clk);
    #1;
    check("ovf_count_sat", ovf_count, 32'hFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
